// File: rtl/corelet_seq.sv
// corelet_seq: tile sequencer for the corelet.
// Drives SRAM reads, L0/IFIFO loads, MAC phases and OFIFO drain.
module corelet_seq #(
  parameter int row        = 8,
  parameter int col        = 8,
  parameter int fifo_depth = 64,
  parameter int addr_bw    = 11
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               abort,
  input  logic               mode,
  input  logic [7:0]         k_len,
  input  logic [addr_bw-1:0] mem_base,
  input  logic               l0_o_full,
  input  logic               ififo_o_full,
  input  logic               ofifo_valid,
  output logic [33:0]        inst,
  output logic               mem_cen,
  output logic [addr_bw-1:0] mem_a,
  output logic               busy,
  output logic               done,
  output logic               err
);

  localparam int cw = $clog2(256 + row + col);

  typedef enum logic [2:0] {
    IDLE, LOAD, KLOAD, EXEC, FLUSH, DRAIN, DONE
  } state_t;

  state_t state, state_n;

  logic [cw-1:0]      cnt, cnt_n, cnt_i;
  logic [cw-1:0]      k_w, e_len;
  logic [7:0]         k_q, k_n;
  logic               md_q, md_n;
  logic [addr_bw-1:0] base_q, base_n;
  logic [33:0]        inst_n;
  logic               cen_n, done_n, err_n;
  logic [addr_bw-1:0] a_n;
  logic               k_ok;

  assign k_w   = cw'(k_q);
  assign e_len = k_w + cw'(row + col - 1);
  assign cnt_i = cnt + cw'(1);
  assign k_ok  = (k_len != 8'd0)
              && (32'(k_len) <= 32'(fifo_depth));
  assign busy  = (state != IDLE);

  // Outputs are computed for the next cycle and registered.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    k_n     = k_q;
    md_n    = md_q;
    base_n  = base_q;
    inst_n  = '0;
    cen_n   = 1'b1;
    a_n     = mem_a;
    done_n  = 1'b0;
    err_n   = 1'b0;
    if (abort) begin
      state_n = IDLE;
      cnt_n   = '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            if (k_ok) begin
              state_n = LOAD;
              cnt_n   = '0;
              k_n     = k_len;
              md_n    = mode;
              base_n  = mem_base;
              cen_n   = 1'b0;
              a_n     = mem_base;
            end else begin
              err_n = 1'b1;
            end
          end
        end
        LOAD: begin
          if (inst[2] && (l0_o_full || ififo_o_full)) begin
            state_n = IDLE;
            cnt_n   = '0;
            err_n   = 1'b1;
            a_n     = '0;
          end else if (cnt < k_w) begin
            // Write lags read by the SRAM latency.
            cnt_n     = cnt_i;
            inst_n[2] = 1'b1;
            inst_n[5] = 1'b1;
            if (cnt_i < k_w) begin
              cen_n = 1'b0;
              a_n   = base_q + addr_bw'(cnt_i);
            end
          end else begin
            cnt_n     = '0;
            inst_n[3] = 1'b1;
            if (md_q) begin
              state_n     = EXEC;
              inst_n[1:0] = 2'b10;
              inst_n[4]   = 1'b1;
            end else begin
              state_n     = KLOAD;
              inst_n[1:0] = 2'b01;
            end
          end
        end
        KLOAD: begin
          inst_n[3] = 1'b1;
          if (cnt < cw'(col - 1)) begin
            cnt_n       = cnt_i;
            inst_n[1:0] = 2'b01;
          end else begin
            state_n     = EXEC;
            cnt_n       = '0;
            inst_n[1:0] = 2'b10;
          end
        end
        EXEC: begin
          if (cnt < e_len - cw'(1)) begin
            cnt_n       = cnt_i;
            inst_n[1:0] = 2'b10;
            inst_n[3]   = (cnt_i < k_w);
            inst_n[4]   = md_q && (cnt_i < k_w);
          end else begin
            state_n = FLUSH;
            cnt_n   = '0;
          end
        end
        FLUSH: begin
          if (cnt == '0) begin
            cnt_n = cnt_i;
          end else begin
            state_n = DRAIN;
            cnt_n   = '0;
          end
        end
        DRAIN: begin
          if (cnt == cw'(row)) begin
            state_n = DONE;
            cnt_n   = '0;
            done_n  = 1'b1;
          end else if (ofifo_valid) begin
            cnt_n      = cnt_i;
            inst_n[6]  = 1'b1;
            inst_n[33] = !md_q;
          end
        end
        DONE: begin
          state_n = IDLE;
        end
        default: begin
          state_n = IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      cnt     <= '0;
      k_q     <= '0;
      md_q    <= 1'b0;
      base_q  <= '0;
      inst    <= '0;
      mem_cen <= 1'b1;
      mem_a   <= '0;
      done    <= 1'b0;
      err     <= 1'b0;
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      k_q     <= k_n;
      md_q    <= md_n;
      base_q  <= base_n;
      inst    <= inst_n;
      mem_cen <= cen_n;
      mem_a   <= a_n;
      done    <= done_n;
      err     <= err_n;
    end
  end

endmodule

// File: tb/tb_corelet_seq.sv
// tb_corelet_seq: directed bench for corelet_seq.
// Each scenario task drives a tile and checks its own results.
module tb_corelet_seq;

  logic        clk = 1'b0;
  logic        reset, start, abort, mode;
  logic [7:0]  k_len;
  logic [10:0] mem_base;
  logic        l0_o_full, ififo_o_full, ofifo_valid;
  logic [33:0] inst;
  logic        mem_cen;
  logic [10:0] mem_a;
  logic        busy, done, err;

  int errs = 0;
  int checks = 0;

  int n_addr, n_wr, n_kl, n_ex, n_ex3, n_ex4;
  int n_rd, n_33, n_done, done_at, bad;
  logic post_busy, post_done;
  logic [10:0] addrs [16];

  always #5 clk = ~clk;

  corelet_seq dut (
    .clk(clk), .reset(reset), .start(start),
    .abort(abort), .mode(mode), .k_len(k_len),
    .mem_base(mem_base), .l0_o_full(l0_o_full),
    .ififo_o_full(ififo_o_full),
    .ofifo_valid(ofifo_valid), .inst(inst),
    .mem_cen(mem_cen), .mem_a(mem_a), .busy(busy),
    .done(done), .err(err)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Runs one tile from IDLE, gathering per-cycle statistics.
  task automatic run_tile(input int budget,
                          input logic [3:0] vpat);
    logic pv, pcen;
    n_addr = 0; n_wr = 0; n_kl = 0; n_ex = 0;
    n_ex3 = 0; n_ex4 = 0; n_rd = 0; n_33 = 0;
    n_done = 0; done_at = -1; bad = 0;
    post_busy = 1'b1; post_done = 1'b1;
    pcen = 1'b1;
    start = 1'b1;
    ofifo_valid = vpat[0];
    for (int t = 1; t <= budget; t++) begin
      pv = ofifo_valid;
      tick;
      start = 1'b0;
      if (done_at >= 0 && t == done_at + 1) begin
        post_busy = busy;
        post_done = done;
        break;
      end
      if (!mem_cen) begin
        if (n_addr < 16) addrs[n_addr] = mem_a;
        n_addr++;
      end
      if (inst[2]) begin
        n_wr++;
        if (pcen) bad++;
      end
      if (inst[5] !== inst[2]) bad++;
      if (inst[1:0] == 2'b01) begin
        n_kl++;
        if (!inst[3] || inst[4]) bad++;
      end
      if (inst[1:0] == 2'b10) begin
        n_ex++;
        if (inst[3]) n_ex3++;
        if (inst[4]) n_ex4++;
      end
      if (inst[1:0] == 2'b11) bad++;
      if (inst[6]) begin
        n_rd++;
        if (!pv) bad++;
      end
      if (inst[33]) n_33++;
      if (!mode && inst[33] !== inst[6]) bad++;
      if (inst[32:7] != 26'd0) bad++;
      if (!busy) bad++;
      if (done) begin
        n_done++;
        if (done_at < 0) done_at = t;
      end
      pcen = mem_cen;
      ofifo_valid = vpat[t % 4];
    end
  endtask

  task automatic test_reset;
    reset = 1'b1; start = 1'b1; abort = 1'b1;
    mode = 1'b1; k_len = 8'd4; mem_base = 11'h055;
    l0_o_full = 1'b0; ififo_o_full = 1'b0;
    ofifo_valid = 1'b1;
    tick;
    tick;
    reset = 1'b0; start = 1'b0; abort = 1'b0;
    checks++;
    if (inst !== 34'd0) begin
      errs++; $display("FAIL rst_inst got %h want 0", inst);
    end
    checks++;
    if (mem_cen !== 1'b1) begin
      errs++; $display("FAIL rst_cen got %b want 1", mem_cen);
    end
    checks++;
    if (mem_a !== 11'd0) begin
      errs++; $display("FAIL rst_a got %h want 0", mem_a);
    end
    checks++;
    if ({busy, done, err} !== 3'b000) begin
      errs++;
      $display("FAIL rst_flags got %b want 000",
               {busy, done, err});
    end
  endtask

  task automatic test_bad_start;
    int n_err;
    n_err = 0;
    k_len = 8'd0; start = 1'b1;
    tick;
    start = 1'b0;
    if (err) n_err++;
    checks++;
    if (busy !== 1'b0) begin
      errs++; $display("FAIL k0_busy got %b want 0", busy);
    end
    tick;
    if (err) n_err++;
    k_len = 8'd65; start = 1'b1;
    tick;
    start = 1'b0;
    if (err) n_err++;
    checks++;
    if (busy !== 1'b0) begin
      errs++; $display("FAIL k65_busy got %b want 0", busy);
    end
    tick;
    if (err) n_err++;
    checks++;
    if (n_err != 2) begin
      errs++; $display("FAIL err_pulses got %0d want 2", n_err);
    end
    k_len = 8'd64; start = 1'b1;
    tick;
    checks++;
    if ({busy, err, mem_cen} !== 3'b100) begin
      errs++;
      $display("FAIL k64_accept got %b want 100",
               {busy, err, mem_cen});
    end
    k_len = 8'd0;
    tick;
    start = 1'b0;
    checks++;
    if ({busy, err} !== 2'b10) begin
      errs++;
      $display("FAIL start_busy got %b want 10", {busy, err});
    end
    abort = 1'b1;
    tick;
    abort = 1'b0;
    checks++;
    if ({busy, mem_cen, inst} !== {2'b01, 34'd0}) begin
      errs++;
      $display("FAIL k64_abort got %b %b %h want 0 1 0",
               busy, mem_cen, inst);
    end
  endtask

  task automatic test_os_tile;
    mode = 1'b1; k_len = 8'd4; mem_base = 11'h7FE;
    run_tile(200, 4'b1111);
    checks++;
    if (n_addr != 4 || addrs[0] !== 11'h7FE
        || addrs[1] !== 11'h7FF || addrs[2] !== 11'h000
        || addrs[3] !== 11'h001) begin
      errs++;
      $display("FAIL os_addr got n=%0d %h %h %h %h want 4 7fe 7ff 000 001",
               n_addr, addrs[0], addrs[1], addrs[2], addrs[3]);
    end
    checks++;
    if (n_wr != 4) begin
      errs++; $display("FAIL os_wr got %0d want 4", n_wr);
    end
    checks++;
    if (n_ex != 19 || n_ex3 != 4 || n_ex4 != 4) begin
      errs++;
      $display("FAIL os_exec got %0d/%0d/%0d want 19/4/4",
               n_ex, n_ex3, n_ex4);
    end
    checks++;
    if (n_kl != 0) begin
      errs++; $display("FAIL os_kload got %0d want 0", n_kl);
    end
    checks++;
    if (n_rd != 8 || n_33 != 0) begin
      errs++;
      $display("FAIL os_drain got rd=%0d acc=%0d want 8 0",
               n_rd, n_33);
    end
    checks++;
    if (n_done != 1 || done_at != 36) begin
      errs++;
      $display("FAIL os_done got n=%0d at=%0d want 1 at 36",
               n_done, done_at);
    end
    checks++;
    if (bad != 0 || post_busy !== 1'b0 || post_done !== 1'b0)
    begin
      errs++;
      $display("FAIL os_proto got bad=%0d busy=%b done=%b want 0 0 0",
               bad, post_busy, post_done);
    end
  endtask

  task automatic test_ws_tile;
    mode = 1'b0; k_len = 8'd3; mem_base = 11'h100;
    run_tile(200, 4'b1111);
    checks++;
    if (n_kl != 8) begin
      errs++; $display("FAIL ws_kload got %0d want 8", n_kl);
    end
    checks++;
    if (n_ex != 18 || n_ex3 != 3 || n_ex4 != 0) begin
      errs++;
      $display("FAIL ws_exec got %0d/%0d/%0d want 18/3/0",
               n_ex, n_ex3, n_ex4);
    end
    checks++;
    if (n_rd != 8 || n_33 != 8) begin
      errs++;
      $display("FAIL ws_drain got rd=%0d acc=%0d want 8 8",
               n_rd, n_33);
    end
    checks++;
    if (n_wr != 3 || done_at != 42 || bad != 0) begin
      errs++;
      $display("FAIL ws_misc got wr=%0d at=%0d bad=%0d want 3 42 0",
               n_wr, done_at, bad);
    end
  endtask

  task automatic test_drain_gaps;
    mode = 1'b1; k_len = 8'd1; mem_base = 11'h000;
    run_tile(200, 4'b1001);
    checks++;
    if (n_rd != 8 || bad != 0) begin
      errs++;
      $display("FAIL gap_reads got rd=%0d bad=%0d want 8 0",
               n_rd, bad);
    end
    checks++;
    if (n_done != 1 || done_at != 38) begin
      errs++;
      $display("FAIL gap_done got n=%0d at=%0d want 1 at 38",
               n_done, done_at);
    end
  endtask

  task automatic test_abort;
    int n_d;
    n_d = 0;
    mode = 1'b1; k_len = 8'd2; mem_base = 11'h000;
    ofifo_valid = 1'b1;
    start = 1'b1;
    tick;
    start = 1'b0;
    for (int i = 0; i < 8; i++) tick;
    checks++;
    if (inst[1:0] !== 2'b10) begin
      errs++;
      $display("FAIL ab_exec got op=%b want 10", inst[1:0]);
    end
    abort = 1'b1;
    tick;
    abort = 1'b0;
    checks++;
    if ({busy, mem_cen, done, inst} !== {3'b010, 34'd0}) begin
      errs++;
      $display("FAIL ab_idle got %b %b %b %h want 0 1 0 0",
               busy, mem_cen, done, inst);
    end
    for (int i = 0; i < 40; i++) begin
      tick;
      if (done || busy) n_d++;
    end
    checks++;
    if (n_d != 0) begin
      errs++; $display("FAIL ab_quiet got %0d want 0", n_d);
    end
    mode = 1'b1; k_len = 8'd1;
    run_tile(200, 4'b1111);
    checks++;
    if (done_at != 30 || n_rd != 8 || bad != 0) begin
      errs++;
      $display("FAIL ab_restart got at=%0d rd=%0d bad=%0d want 30 8 0",
               done_at, n_rd, bad);
    end
  endtask

  task automatic test_reset_mid;
    mode = 1'b1; k_len = 8'd4; mem_base = 11'h010;
    ofifo_valid = 1'b1;
    start = 1'b1;
    tick;
    start = 1'b0;
    tick;
    tick;
    checks++;
    if ({mem_cen, mem_a} !== {1'b0, 11'h012}) begin
      errs++;
      $display("FAIL rl_addr got %b %h want 0 012",
               mem_cen, mem_a);
    end
    reset = 1'b1;
    tick;
    reset = 1'b0;
    checks++;
    if ({busy, done, err, mem_cen, mem_a, inst}
        !== {4'b0001, 11'd0, 34'd0}) begin
      errs++;
      $display("FAIL rl_state got b%b d%b e%b c%b a%h i%h want 0 0 0 1 0 0",
               busy, done, err, mem_cen, mem_a, inst);
    end
    mode = 1'b0; k_len = 8'd2;
    run_tile(200, 4'b1111);
    checks++;
    if (done_at != 40 || n_addr != 2
        || addrs[0] !== 11'h010 || addrs[1] !== 11'h011) begin
      errs++;
      $display("FAIL rl_restart got at=%0d n=%0d %h %h want 40 2 010 011",
               done_at, n_addr, addrs[0], addrs[1]);
    end
    mode = 1'b1; k_len = 8'd1; mem_base = 11'h003;
    ofifo_valid = 1'b0;
    start = 1'b1;
    tick;
    start = 1'b0;
    for (int i = 0; i < 30; i++) tick;
    checks++;
    if ({busy, mem_cen, mem_a, inst}
        !== {2'b11, 11'h003, 34'd0}) begin
      errs++;
      $display("FAIL rd_wait got b%b c%b a%h i%h want 1 1 003 0",
               busy, mem_cen, mem_a, inst);
    end
    reset = 1'b1;
    tick;
    reset = 1'b0;
    checks++;
    if ({busy, mem_cen, mem_a} !== {2'b01, 11'd0}) begin
      errs++;
      $display("FAIL rd_reset got b%b c%b a%h want 0 1 000",
               busy, mem_cen, mem_a);
    end
  endtask

  task automatic test_overflow;
    int n_w;
    n_w = 0;
    mode = 1'b1; k_len = 8'd4; mem_base = 11'h020;
    l0_o_full = 1'b1;
    start = 1'b1;
    tick;
    start = 1'b0;
    checks++;
    if (inst[2] !== 1'b0) begin
      errs++; $display("FAIL of_first got %b want 0", inst[2]);
    end
    tick;
    checks++;
    if (inst[2] !== 1'b1) begin
      errs++; $display("FAIL of_write got %b want 1", inst[2]);
    end
    tick;
    checks++;
    if ({err, busy, mem_cen, mem_a, inst}
        !== {3'b101, 11'd0, 34'd0}) begin
      errs++;
      $display("FAIL of_abort got e%b b%b c%b a%h i%h want 1 0 1 0 0",
               err, busy, mem_cen, mem_a, inst);
    end
    for (int i = 0; i < 10; i++) begin
      tick;
      if (inst[2] || err) n_w++;
    end
    checks++;
    if (n_w != 0) begin
      errs++; $display("FAIL of_quiet got %0d want 0", n_w);
    end
    l0_o_full = 1'b0;
  endtask

  initial begin
    test_reset;
    test_bad_start;
    test_os_tile;
    test_ws_tile;
    test_drain_gaps;
    test_abort;
    test_reset_mid;
    test_overflow;
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

endmodule
